pcie_tl_tx_vc_sched: RTL and testbench

Parametrised transmit-side virtual-channel scheduler for the PCIe Transaction Layer. It buffers TLPs per virtual channel (NUM_VC channels), gates each channel with its own credit counter, and arbitrates with weighted round-robin. The winning TLP goes to the Data Link Layer over a valid/ready interface. It sits between the TL header/payload assembly logic and the DLL TX, and extends the fixed two-VC, single fc_valid TX path with per-VC credits, weights and a generic channel count.

---
 rtl/PCIe_PKG.sv | 15 +
 rtl/pcie_vc_fifo.sv | 49 ++++
 rtl/pcie_tl_tx_vc_sched.sv | 166 ++++++++++++++++
 tb/tb_pcie_tl_tx_vc_sched.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/PCIe_PKG.sv
// Shared Transaction Layer types and sizes for the TX scheduling path.
package PCIe_PKG;

  localparam int unsigned PCIe_TL_TLP_PACKET_SIZE = 128;
  localparam int unsigned PCIe_TL_NUM_VC_MAX      = 8;
  localparam int unsigned PCIe_TL_VC_ID_W         = $clog2(PCIe_TL_NUM_VC_MAX);

  typedef logic [PCIe_TL_VC_ID_W-1:0] vc_id_t;

  typedef enum logic {
    SELECT = 1'b0,
    BURST  = 1'b1
  } sched_state_e;

endpackage

// File: rtl/pcie_vc_fifo.sv
// Per-VC TLP FIFO: flop-array storage, head entry always presented, registered flags.
module pcie_vc_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam logic [PW-1:0] FULL_XOR = PW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q, wr_ptr_d, rd_ptr_d;
  logic             do_push, do_pop;

  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign wr_ptr_d = wr_ptr_q + PW'(do_push);
  assign rd_ptr_d = rd_ptr_q + PW'(do_pop);
  assign rdata    = mem[rd_ptr_q[AW-1:0]];

  // Extra pointer bit distinguishes full from empty when the addresses match.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      full     <= (wr_ptr_d ^ rd_ptr_d) == FULL_XOR;
      empty    <= wr_ptr_d == rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/pcie_tl_tx_vc_sched.sv
// TX virtual-channel scheduler: per-VC FIFOs, credit gating, weighted round-robin
// arbitration and a single egress register towards the DLL.
module pcie_tl_tx_vc_sched
  import PCIe_PKG::*;
#(
  parameter int unsigned NUM_VC      = 4,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned TLP_W       = PCIe_TL_TLP_PACKET_SIZE,
  parameter int unsigned CREDIT_W    = 8,
  parameter int unsigned INIT_CREDIT = 16,
  parameter int unsigned WEIGHT_W    = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         tlp_valid_i,
  input  logic [TLP_W-1:0]             tlp_i,
  input  logic [$clog2(NUM_VC)-1:0]    tlp_vc_i,
  output logic                         tlp_ready_o,
  input  logic [NUM_VC-1:0]            fc_update_i,
  input  logic [NUM_VC*CREDIT_W-1:0]   fc_credit_i,
  input  logic [NUM_VC*WEIGHT_W-1:0]   vc_weight_i,
  output logic                         tlp_valid_o,
  output logic [TLP_W-1:0]             tlp_o,
  output logic [$clog2(NUM_VC)-1:0]    tlp_vc_o,
  input  logic                         tlp_ready_i,
  output logic [NUM_VC-1:0]            vc_empty_o,
  output logic [NUM_VC-1:0]            vc_full_o
);

  localparam int unsigned VC_W = $clog2(NUM_VC);
  localparam int unsigned CW1  = CREDIT_W + 1;
  localparam logic [CW1-1:0] CREDIT_MAX = {1'b0, {CREDIT_W{1'b1}}};

  logic [NUM_VC-1:0]                push_v, pop_v, fifo_full, fifo_empty, elig;
  logic [TLP_W-1:0]                 fifo_rdata [NUM_VC];
  logic [NUM_VC-1:0][CREDIT_W-1:0]  credit_q, credit_d;
  logic [CREDIT_W-1:0]              ret;
  logic [CW1-1:0]                   sum;

  sched_state_e        state_q, state_d;
  logic [VC_W-1:0]     gnt_vc_q, gnt_vc_d, issue_vc, scan_vc;
  logic [WEIGHT_W-1:0] burst_q, burst_d, weight_sel;
  logic                out_free, cont, scan_found, issue, new_grant;

  function automatic logic [VC_W-1:0] rr_idx(input logic [VC_W-1:0] base, input int unsigned off);
    return VC_W'((32'(base) + off) % NUM_VC);
  endfunction

  assign tlp_ready_o = rst_n && !fifo_full[tlp_vc_i];
  assign vc_empty_o  = fifo_empty;
  assign vc_full_o   = fifo_full;

  for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
    assign push_v[v] = tlp_valid_i && tlp_ready_o && (tlp_vc_i == VC_W'(v));
    assign pop_v[v]  = issue && (issue_vc == VC_W'(v));
    assign elig[v]   = !fifo_empty[v] && (credit_q[v] != '0);

    pcie_vc_fifo #(
      .WIDTH (TLP_W),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push_v[v]),
      .wdata (tlp_i),
      .pop   (pop_v[v]),
      .rdata (fifo_rdata[v]),
      .full  (fifo_full[v]),
      .empty (fifo_empty[v])
    );
  end

  // Credit return and issue in the same cycle both apply; only the top end saturates.
  always_comb begin
    credit_d = credit_q;
    ret      = '0;
    sum      = '0;
    for (int unsigned v = 0; v < NUM_VC; v++) begin
      ret         = fc_update_i[v] ? fc_credit_i[v*CREDIT_W +: CREDIT_W] : '0;
      sum         = CW1'(credit_q[v]) + CW1'(ret) - CW1'(pop_v[v]);
      credit_d[v] = (sum > CREDIT_MAX) ? '1 : sum[CREDIT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned v = 0; v < NUM_VC; v++) credit_q[v] <= CREDIT_W'(INIT_CREDIT);
    end else begin
      credit_q <= credit_d;
    end
  end

  // Arbiter state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= SELECT;
      gnt_vc_q <= VC_W'(NUM_VC - 1);
      burst_q  <= '0;
    end else begin
      state_q  <= state_d;
      gnt_vc_q <= gnt_vc_d;
      burst_q  <= burst_d;
    end
  end

  // Issue decision: continue the burst, otherwise rescan in the same cycle so a VC switch costs nothing.
  always_comb begin
    scan_found = 1'b0;
    scan_vc    = gnt_vc_q;
    for (int unsigned i = 1; i <= NUM_VC; i++) begin
      if (!scan_found && elig[rr_idx(gnt_vc_q, i)]) begin
        scan_found = 1'b1;
        scan_vc    = rr_idx(gnt_vc_q, i);
      end
    end
    cont      = (state_q == BURST) && elig[gnt_vc_q] && (burst_q != '0);
    out_free  = !tlp_valid_o || tlp_ready_i;
    issue     = 1'b0;
    issue_vc  = gnt_vc_q;
    new_grant = 1'b0;
    if (out_free) begin
      if (cont) begin
        issue = 1'b1;
      end else if (scan_found) begin
        issue     = 1'b1;
        issue_vc  = scan_vc;
        new_grant = 1'b1;
      end
    end
  end

  // Next state: a fresh grant's own issue consumes the first unit of its weight.
  always_comb begin
    state_d    = state_q;
    gnt_vc_d   = gnt_vc_q;
    burst_d    = burst_q;
    weight_sel = vc_weight_i[issue_vc*WEIGHT_W +: WEIGHT_W];
    if (new_grant) begin
      gnt_vc_d = issue_vc;
      burst_d  = (weight_sel == '0) ? '0 : weight_sel - WEIGHT_W'(1);
    end else if (issue) begin
      burst_d  = burst_q - WEIGHT_W'(1);
    end
    if (issue) begin
      state_d = (burst_d == '0) ? SELECT : BURST;
    end else if ((state_q == BURST) && !cont) begin
      state_d = SELECT;
    end
  end

  // Egress register: loads on issue, otherwise holds until the DLL accepts.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tlp_valid_o <= 1'b0;
      tlp_o       <= '0;
      tlp_vc_o    <= '0;
    end else if (issue) begin
      tlp_valid_o <= 1'b1;
      tlp_o       <= fifo_rdata[issue_vc];
      tlp_vc_o    <= issue_vc;
    end else if (tlp_ready_i) begin
      tlp_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pcie_tl_tx_vc_sched.sv
// Directed bench for the TX VC scheduler with a per-VC ordered scoreboard.
module tb_pcie_tl_tx_vc_sched;
  import PCIe_PKG::*;

  localparam int unsigned NUM_VC   = 4;
  localparam int unsigned TLP_W    = PCIe_TL_TLP_PACKET_SIZE;
  localparam int unsigned CREDIT_W = 8;
  localparam int unsigned WEIGHT_W = 4;

  typedef logic [TLP_W-1:0] word_t;
  typedef struct packed {
    logic [1:0] vc;
    word_t      data;
  } item_t;

  logic                       clk = 1'b0;
  logic                       rst_n;
  logic                       tlp_valid_i;
  word_t                      tlp_i;
  logic [1:0]                 tlp_vc_i;
  logic                       tlp_ready_o;
  logic [NUM_VC-1:0]          fc_update_i;
  logic [NUM_VC*CREDIT_W-1:0] fc_credit_i;
  logic [NUM_VC*WEIGHT_W-1:0] vc_weight_i;
  logic                       tlp_valid_o;
  word_t                      tlp_o;
  logic [1:0]                 tlp_vc_o;
  logic                       tlp_ready_i;
  logic [NUM_VC-1:0]          vc_empty_o;
  logic [NUM_VC-1:0]          vc_full_o;

  int    n_vec = 0;
  int    n_err = 0;
  int    cyc   = 0;
  item_t exp_q[$];
  int    obs_vc[$];
  int    obs_cyc[$];

  pcie_tl_tx_vc_sched #(
    .NUM_VC      (NUM_VC),
    .FIFO_DEPTH  (8),
    .TLP_W       (TLP_W),
    .CREDIT_W    (CREDIT_W),
    .INIT_CREDIT (16),
    .WEIGHT_W    (WEIGHT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tlp_valid_i (tlp_valid_i),
    .tlp_i       (tlp_i),
    .tlp_vc_i    (tlp_vc_i),
    .tlp_ready_o (tlp_ready_o),
    .fc_update_i (fc_update_i),
    .fc_credit_i (fc_credit_i),
    .vc_weight_i (vc_weight_i),
    .tlp_valid_o (tlp_valid_o),
    .tlp_o       (tlp_o),
    .tlp_vc_o    (tlp_vc_o),
    .tlp_ready_i (tlp_ready_i),
    .vc_empty_o  (vc_empty_o),
    .vc_full_o   (vc_full_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input word_t obs, input word_t exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic word_t mk(input int unsigned t, input int unsigned vc, input int unsigned k);
    return (word_t'(t) << 100) | word_t'({8'(t), 8'(vc), 16'(k)});
  endfunction

  task automatic push_n(input int unsigned vc, input int unsigned n, input int unsigned t);
    for (int unsigned k = 0; k < n; k++) begin
      tlp_valid_i = 1'b1;
      tlp_vc_i    = 2'(vc);
      tlp_i       = mk(t, vc, k);
      tick();
    end
    tlp_valid_i = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || tlp_valid_o) && n < 200) begin
      tick();
      n++;
    end
    check(tag, word_t'(n < 200), word_t'(1));
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    tlp_valid_i = 1'b0;
    fc_update_i = '0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    exp_q.delete();
    obs_vc.delete();
    obs_cyc.delete();
  endtask

  // Scoreboard: compare each DLL transfer with the oldest pending TLP of that VC, then log accepted pushes.
  always @(negedge clk) begin
    int idx;
    if (rst_n) begin
      if (tlp_valid_o && tlp_ready_i) begin
        idx = -1;
        for (int i = 0; i < int'(exp_q.size()); i++)
          if (idx < 0 && exp_q[i].vc == tlp_vc_o) idx = i;
        obs_vc.push_back(int'(tlp_vc_o));
        obs_cyc.push_back(cyc);
        if (idx < 0) begin
          n_vec++;
          n_err++;
          $error("FAIL sb_extra: observed vc %0d data 0x%0h, expected no pending TLP", tlp_vc_o, tlp_o);
        end else begin
          check("sb_data", tlp_o, exp_q[idx].data);
          exp_q.delete(idx);
        end
      end
      if (tlp_valid_i && tlp_ready_o) exp_q.push_back('{vc: tlp_vc_i, data: tlp_i});
    end
  end

  initial begin
    int exp_ord[12] = '{0, 0, 0, 1, 0, 0, 0, 1, 1, 1, 1, 1};

    rst_n       = 1'b0;
    tlp_valid_i = 1'b0;
    tlp_i       = '0;
    tlp_vc_i    = '0;
    fc_update_i = '0;
    fc_credit_i = '0;
    vc_weight_i = {4'd1, 4'd1, 4'd1, 4'd1};
    tlp_ready_i = 1'b0;

    // Reset values
    tick();
    tick();
    check("rst_ready", word_t'(tlp_ready_o), word_t'(0));
    check("rst_valid", word_t'(tlp_valid_o), word_t'(0));
    check("rst_tlp", tlp_o, word_t'(0));
    check("rst_vc", word_t'(tlp_vc_o), word_t'(0));
    check("rst_empty", word_t'(vc_empty_o), word_t'(4'hF));
    check("rst_full", word_t'(vc_full_o), word_t'(0));
    rst_n = 1'b1;
    #1;
    check("rst_ready_after", word_t'(tlp_ready_o), word_t'(1));

    // Latency and back-to-back issue on one VC
    tlp_ready_i = 1'b1;
    tlp_valid_i = 1'b1;
    tlp_vc_i    = 2'd2;
    tlp_i       = mk(1, 2, 0);
    tick();
    check("t1_valid_n1", word_t'(tlp_valid_o), word_t'(0));
    tlp_i = mk(1, 2, 1);
    tick();
    check("t1_valid_n2", word_t'(tlp_valid_o), word_t'(1));
    check("t1_vc_n2", word_t'(tlp_vc_o), word_t'(2));
    tlp_i = mk(1, 2, 2);
    tick();
    tlp_valid_i = 1'b0;
    drain("t1_drain");
    check("t1_count", word_t'(obs_vc.size()), word_t'(3));
    for (int i = 0; i < 3; i++) check("t1_vc", word_t'(obs_vc[i]), word_t'(2));
    check("t1_b2b", word_t'(obs_cyc[2] - obs_cyc[0]), word_t'(2));
    check("t1_credit", word_t'(dut.credit_q[2]), word_t'(13));

    // Weighted round-robin, VC0 weight 3 vs VC1 weight 1
    do_reset();
    vc_weight_i = {4'd1, 4'd1, 4'd1, 4'd3};
    tlp_ready_i = 1'b0;
    push_n(0, 6, 2);
    push_n(1, 6, 2);
    check("t2_empty", word_t'(vc_empty_o), word_t'(4'b1100));
    check("t2_head_vc", word_t'(tlp_vc_o), word_t'(0));
    tlp_ready_i = 1'b1;
    drain("t2_drain");
    check("t2_count", word_t'(obs_vc.size()), word_t'(12));
    for (int i = 0; i < 12; i++) check("t2_order", word_t'(obs_vc[i]), word_t'(exp_ord[i]));
    check("t2_no_idle", word_t'(obs_cyc[11] - obs_cyc[0]), word_t'(11));

    // Credit exhaustion and return on VC1
    do_reset();
    vc_weight_i = {4'd1, 4'd1, 4'd0, 4'd1};
    tlp_ready_i = 1'b1;
    push_n(1, 14, 3);
    drain("t3_burn_drain");
    check("t3_credit_2", word_t'(dut.credit_q[1]), word_t'(2));
    obs_vc.delete();
    push_n(1, 4, 4);
    repeat (8) tick();
    check("t3_stall_count", word_t'(obs_vc.size()), word_t'(2));
    check("t3_stall_valid", word_t'(tlp_valid_o), word_t'(0));
    check("t3_stall_nonempty", word_t'(vc_empty_o[1]), word_t'(0));
    check("t3_credit_0", word_t'(dut.credit_q[1]), word_t'(0));
    fc_update_i = 4'b0010;
    fc_credit_i = {8'd0, 8'd0, 8'd2, 8'd0};
    tick();
    fc_update_i = '0;
    check("t3_upd_n", word_t'(tlp_valid_o), word_t'(0));
    tick();
    check("t3_upd_n1_valid", word_t'(tlp_valid_o), word_t'(1));
    check("t3_upd_n1_vc", word_t'(tlp_vc_o), word_t'(1));
    drain("t3_drain");
    check("t3_count", word_t'(obs_vc.size()), word_t'(4));
    check("t3_credit_end", word_t'(dut.credit_q[1]), word_t'(0));
    fc_update_i = 4'b0001;
    fc_credit_i = {8'd0, 8'd0, 8'd0, 8'd255};
    tick();
    fc_update_i = '0;
    check("t3_sat", word_t'(dut.credit_q[0]), word_t'(255));

    // Output hold under backpressure
    do_reset();
    vc_weight_i = {4'd1, 4'd1, 4'd1, 4'd1};
    tlp_ready_i = 1'b0;
    push_n(0, 3, 5);
    tick();
    for (int i = 0; i < 5; i++) begin
      check("t4_hold_valid", word_t'(tlp_valid_o), word_t'(1));
      check("t4_hold_tlp", tlp_o, mk(5, 0, 0));
      check("t4_hold_vc", word_t'(tlp_vc_o), word_t'(0));
      tick();
    end
    check("t4_credit", word_t'(dut.credit_q[0]), word_t'(15));
    check("t4_nonempty", word_t'(vc_empty_o[0]), word_t'(0));
    tlp_ready_i = 1'b1;
    drain("t4_drain");
    check("t4_count", word_t'(obs_vc.size()), word_t'(3));

    // Full FIFO on VC3
    do_reset();
    tlp_ready_i = 1'b0;
    push_n(0, 1, 6);
    push_n(3, 8, 6);
    check("t5_full", word_t'(vc_full_o), word_t'(4'b1000));
    check("t5_empty", word_t'(vc_empty_o), word_t'(4'b0111));
    tlp_valid_i = 1'b1;
    tlp_vc_i    = 2'd3;
    tlp_i       = mk(6, 3, 99);
    #1;
    check("t5_ready_vc3", word_t'(tlp_ready_o), word_t'(0));
    tlp_vc_i = 2'd0;
    #1;
    check("t5_ready_vc0", word_t'(tlp_ready_o), word_t'(1));
    tlp_vc_i = 2'd3;
    tick();
    tlp_valid_i = 1'b0;
    push_n(0, 1, 7);
    tlp_ready_i = 1'b1;
    drain("t5_drain");
    check("t5_count", word_t'(obs_vc.size()), word_t'(10));

    // Reset mid-burst
    do_reset();
    vc_weight_i = {4'd1, 4'd1, 4'd1, 4'd3};
    tlp_ready_i = 1'b0;
    push_n(0, 3, 8);
    check("t6_burst", word_t'(dut.state_q == BURST), word_t'(1));
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    exp_q.delete();
    obs_vc.delete();
    check("t6_empty", word_t'(vc_empty_o), word_t'(4'hF));
    check("t6_valid", word_t'(tlp_valid_o), word_t'(0));
    for (int v = 0; v < 4; v++) check("t6_credit", word_t'(dut.credit_q[v]), word_t'(16));
    check("t6_gnt", word_t'(dut.gnt_vc_q), word_t'(3));
    tlp_ready_i = 1'b1;
    push_n(0, 1, 9);
    drain("t6_drain");
    check("t6_count", word_t'(obs_vc.size()), word_t'(1));
    check("t6_first_vc", word_t'(obs_vc[0]), word_t'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
